// File: rtl/imem_loader.sv
// Boot loader: streams a length/PC header plus program words into instruction memory,
// then releases the core. Define IMEM_LOADER_CHECKSUM_EN to require a sum-check trailer.
module imem_loader #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [XLEN-1:0] s_data,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            cpu_rst,
  output logic [XLEN-1:0] pc_init,
  output logic            done,
  output logic            error,
  output logic [AW:0]     load_cnt
);

  typedef enum logic [2:0] {S_LEN, S_PC, S_DATA, S_CHK, S_RUN, S_ERR} state_t;

  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(DEPTH);

  state_t      state, state_nxt;
  logic [AW:0] len;
  logic        acc;
  logic        last_data;

  assign acc       = s_valid && s_ready;
  assign last_data = (load_cnt == len - 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [XLEN-1:0] sum;

  always_ff @(posedge clk) begin
    if (rst)                         sum <= '0;
    else if (acc && state == S_DATA) sum <= sum + s_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN:
        if (acc) state_nxt = (s_data == '0 || s_data > DEPTH_W) ? S_ERR : S_PC;
      S_PC:
        if (acc) state_nxt = (s_data[1:0] != 2'b00) ? S_ERR : S_DATA;
      S_DATA:
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (acc && last_data) state_nxt = S_CHK;
      S_CHK:
        if (acc) state_nxt = (s_data == sum) ? S_RUN : S_ERR;
`else
        if (acc && last_data) state_nxt = S_RUN;
`endif
      default: state_nxt = state;
    endcase
  end

  // rst gates s_ready so no word is consumed during the reset cycle itself
  always_comb begin
    s_ready = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    case (state)
      S_LEN, S_PC, S_DATA: s_ready = !rst;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:               s_ready = !rst;
`endif
      S_RUN:               done    = 1'b1;
      S_ERR:               error   = 1'b1;
      default: ;
    endcase
  end

  // cpu_rst lags RUN by one edge so the final memory write commits before fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      pc_init   <= '0;
      len       <= '0;
      load_cnt  <= '0;
    end else begin
      mem_we  <= acc && state == S_DATA;
      cpu_rst <= (state != S_RUN);
      if (acc && state == S_LEN) len <= s_data[AW:0];
      if (acc && state == S_PC && s_data[1:0] == 2'b00) pc_init <= s_data;
      if (acc && state == S_DATA) begin
        mem_addr  <= load_cnt[AW-1:0];
        mem_wdata <= s_data;
        load_cnt  <= load_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: an image-level model predicts every cycle's
// writes, handshake and release/abort status from the image contents alone.
module tb_imem_loader;
  localparam int XLEN  = 32;
  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [XLEN-1:0] s_data;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            cpu_rst;
  logic [XLEN-1:0] pc_init;
  logic            done;
  logic            error;
  logic [AW:0]     load_cnt;

  int checks   = 0;
  int failures = 0;

  imem_loader #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .pc_init(pc_init), .done(done), .error(error), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'($urandom_range(0, 1));
    s_data  = $urandom;
    #1 chk("rst_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("rst_we",    64'(mem_we),    64'd0);
    chk("rst_addr",  64'(mem_addr),  64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_cpu",   64'(cpu_rst),   64'd1);
    chk("rst_pc",    64'(pc_init),   64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_err",   64'(error),     64'd0);
    chk("rst_cnt",   64'(load_cnt),  64'd0);
    chk("rst_rdy1",  64'(s_ready),   64'd1);
  endtask

  // pct<0 toggles s_valid every cycle; stop_after>0 abandons the image after that many accepts
  task automatic run_image(input logic [XLEN-1:0] img[$], input int pct, input int stop_after,
                           input int tail);
    logic [XLEN-1:0] n, sum, w;
    logic            len_ok, pc_ok, ok, acc, prev_data;
    int              n_cons, idx, term_t, prev_idx, cyc;
    n      = img[0];
    len_ok = (n != 0) && (n <= DEPTH);
    pc_ok  = (img.size() > 1) ? (img[1][1:0] == 2'b00) : 1'b0;
    ok     = len_ok && pc_ok;
    sum    = '0;
    if (ok) for (int i = 0; i < int'(n); i++) sum += img[2+i];
    n_cons = !len_ok ? 1 : !pc_ok ? 2 : int'(n) + 2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (ok) begin
      n_cons++;
      ok = (img[n_cons-1] == sum);
    end
`endif
    idx = 0; term_t = -1; prev_data = 1'b0; prev_idx = 0; cyc = 0;
    while (1) begin
      @(negedge clk);
      #1;
      if (idx == n_cons) term_t++;
      chk("we", 64'(mem_we), 64'(prev_data));
      if (prev_data) begin
        chk("addr",  64'(mem_addr),  64'(prev_idx - 2));
        chk("wdata", 64'(mem_wdata), 64'(img[prev_idx]));
      end
      chk("ready",   64'(s_ready), 64'(idx < n_cons));
      chk("done",    64'(done),    64'(ok && idx == n_cons));
      chk("error",   64'(error),   64'(!ok && idx == n_cons));
      chk("cpu_rst", 64'(cpu_rst), 64'(!(ok && term_t >= 1)));
      chk("pc_init", 64'(pc_init), (len_ok && pc_ok && idx >= 2) ? 64'(img[1]) : 64'd0);
      chk("load_cnt", 64'(load_cnt),
          (len_ok && pc_ok && idx > 2) ? 64'((idx - 2 < int'(n)) ? idx - 2 : int'(n)) : 64'd0);
      if (stop_after > 0 && idx >= stop_after) break;
      if (term_t >= tail) break;
      if (++cyc > 2000) begin
        chk("timeout", 64'd1, 64'd0);
        break;
      end
      s_valid = (pct < 0) ? 1'(cyc) : ($urandom_range(0, 99) < pct);
      w       = (idx < img.size()) ? img[idx] : $urandom;
      s_data  = w;
      acc       = s_valid && (idx < n_cons);
      prev_data = acc && len_ok && pc_ok && idx >= 2 && idx < int'(n) + 2;
      prev_idx  = idx;
      if (acc) idx++;
    end
    s_valid = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] csum(input logic [XLEN-1:0] img[$]);
    logic [XLEN-1:0] s = '0;
    for (int i = 2; i < img.size(); i++) s += img[i];
    return s;
  endfunction

  initial begin
    logic [XLEN-1:0] img[$];
    int              nw;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    do_reset();

    // basic image at full rate, then with s_valid toggling
    img = '{32'd2, 32'h0, 32'h00500093, 32'h00600113};
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(csum(img));
`endif
    run_image(img, 100, 0, 4);
    do_reset();
    run_image(img, -1, 0, 4);
    do_reset();

    // header errors: N=0, N=DEPTH+1, misaligned PC
    img = '{32'd0};
    run_image(img, 100, 0, 4);
    do_reset();
    img = '{32'(DEPTH + 1), 32'h0};
    run_image(img, 100, 0, 4);
    do_reset();
    img = '{32'd1, 32'h2, 32'h13};
    run_image(img, 100, 0, 4);
    do_reset();

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = '{32'd2, 32'h40, 32'h00500093, 32'h00600113, 32'h00B001A6};
    run_image(img, 100, 0, 4);
    do_reset();
    img = '{32'd2, 32'h40, 32'h00500093, 32'h00600113, 32'h00B001A7};
    run_image(img, 100, 0, 4);
    do_reset();
`endif

    // abort after the first data word, then a clean image
    img = '{32'd3, 32'h80, 32'h11, 32'h22, 32'h33};
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(csum(img));
`endif
    run_image(img, 100, 3, 4);
    do_reset();
    run_image(img, 70, 0, 4);
    do_reset();

    // full-depth image exercises load_cnt reaching DEPTH
    img = '{32'(DEPTH), 32'h100};
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(csum(img));
`endif
    run_image(img, 100, 0, 4);
    do_reset();

    // random images, occasionally malformed
    for (int t = 0; t < 8; t++) begin
      nw  = $urandom_range(1, 20);
      img = '{32'(nw), {$urandom_range(0, 4095), 2'b00}};
      if ($urandom_range(0, 7) == 0) img[1][0] = 1'b1;
      for (int i = 0; i < nw; i++) img.push_back($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
      img.push_back(csum(img) ^ (($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0));
`endif
      run_image(img, $urandom_range(30, 100), 0, 3);
      do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
